// File: rtl/rpn_regfile_stack.sv
// Register-file LIFO stack for an RPN evaluator: push/pop/swap with top-two read ports.
// Optional STACK_ERR_STICKY_EN: error flags latch until rst instead of pulsing for one cycle.
module rpn_regfile_stack #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32,
  parameter int PTR_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             swap,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] stack_top,
  output logic [WIDTH-1:0] stack_top_minus_one,
  output logic             full,
  output logic             empty,
  output logic [PTR_W-1:0] stack_ptr,
  output logic             err_overflow,
  output logic             err_underflow
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] top_idx;
  logic [IDX_W-1:0] next_idx;
  logic             has_two;
  logic             ovf_reject;
  logic             unf_reject;

  // Indices are only used when the occupancy guarantees they are in range.
  assign wr_idx   = IDX_W'(stack_ptr);
  assign top_idx  = IDX_W'(stack_ptr - PTR_W'(1));
  assign next_idx = IDX_W'(stack_ptr - PTR_W'(2));

  assign empty   = (stack_ptr == '0);
  assign full    = (stack_ptr == PTR_W'(DEPTH));
  assign has_two = (stack_ptr >= PTR_W'(2));

  assign stack_top           = empty   ? '0 : mem[top_idx];
  assign stack_top_minus_one = has_two ? mem[next_idx] : '0;

  // Swap only counts when neither push nor pop is present.
  always_comb begin
    ovf_reject = 1'b0;
    unf_reject = 1'b0;
    if (push && pop) begin
      unf_reject = empty;
    end else if (push) begin
      ovf_reject = full;
    end else if (pop) begin
      unf_reject = empty;
    end else if (swap) begin
      unf_reject = !has_two;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stack_ptr     <= '0;
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      if (push && pop) begin
        if (empty) begin
          mem[0]    <= data_in;
          stack_ptr <= PTR_W'(1);
        end else begin
          mem[top_idx] <= data_in;
        end
      end else if (push) begin
        if (!full) begin
          mem[wr_idx] <= data_in;
          stack_ptr   <= stack_ptr + PTR_W'(1);
        end
      end else if (pop) begin
        if (!empty) begin
          stack_ptr <= stack_ptr - PTR_W'(1);
        end
      end else if (swap) begin
        if (has_two) begin
          mem[top_idx]  <= mem[next_idx];
          mem[next_idx] <= mem[top_idx];
        end
      end
`ifdef STACK_ERR_STICKY_EN
      err_overflow  <= err_overflow  | ovf_reject;
      err_underflow <= err_underflow | unf_reject;
`else
      err_overflow  <= ovf_reject;
      err_underflow <= unf_reject;
`endif
    end
  end

endmodule
